// File: rtl/operand_debouncer_if.sv
// Switch-side bundle for the operand debouncer: raw slide-switch bits in,
// debounced operands plus change/tick strobes out.
interface operand_debouncer_if;
    logic [3:0] raw_a;
    logic [3:0] raw_b;
    logic       raw_c0;
    logic [3:0] a_stable;
    logic [3:0] b_stable;
    logic       c0_stable;
    logic       changed;
    logic       tick;

    modport master (
        output raw_a, raw_b, raw_c0,
        input  a_stable, b_stable, c0_stable, changed, tick
    );

    modport slave (
        input  raw_a, raw_b, raw_c0,
        output a_stable, b_stable, c0_stable, changed, tick
    );
endinterface

// File: rtl/operand_debouncer.sv
// Synchronises and debounces the 9 adder-lab switch bits, sampling on a slow
// prescaler tick and pulsing 'changed' whenever a debounced bit flips.
module operand_debouncer #(
    parameter int TICK_BITS    = 15,
    parameter int STABLE_COUNT = 4,
    parameter int CNT_W        = 4
) (
    input logic clk,
    input logic clr,
    operand_debouncer_if.slave bus
);
    localparam int N = 9;
    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_PENDING = 1'b1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STABLE_COUNT - 1);

    logic [N-1:0]         raw_vec;
    logic [N-1:0]         sync_meta;
    logic [N-1:0]         sync_vec;
    logic [N-1:0]         stable_q;
    logic [N-1:0]         stable_d;
    logic [N-1:0]         state_q;
    logic [N-1:0]         state_d;
    logic [CNT_W-1:0]     cnt_q [N];
    logic [CNT_W-1:0]     cnt_d [N];
    logic [TICK_BITS-1:0] presc_q;
    logic                 tick;
    logic                 changed_q;

    assign raw_vec = {bus.raw_c0, bus.raw_b, bus.raw_a};
    assign tick    = (presc_q == '1);

    // Each bit runs its own IDLE/PENDING machine; nothing moves between ticks.
    always_comb begin
        stable_d = stable_q;
        state_d  = state_q;
        cnt_d    = cnt_q;
        if (tick) begin
            for (int i = 0; i < N; i++) begin
                case (state_q[i])
                    ST_IDLE: begin
                        if (sync_vec[i] != stable_q[i]) begin
                            if (STABLE_COUNT == 1) begin
                                stable_d[i] = sync_vec[i];
                            end else begin
                                state_d[i] = ST_PENDING;
                                cnt_d[i]   = CNT_W'(1);
                            end
                        end
                    end
                    default: begin
                        if (sync_vec[i] == stable_q[i]) begin
                            state_d[i] = ST_IDLE;
                            cnt_d[i]   = '0;
                        end else if (cnt_q[i] == LAST_CNT) begin
                            stable_d[i] = sync_vec[i];
                            state_d[i]  = ST_IDLE;
                            cnt_d[i]    = '0;
                        end else begin
                            cnt_d[i] = cnt_q[i] + CNT_W'(1);
                        end
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            sync_meta <= '0;
            sync_vec  <= '0;
            presc_q   <= '0;
            stable_q  <= '0;
            state_q   <= {N{ST_IDLE}};
            changed_q <= 1'b0;
            for (int i = 0; i < N; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync_meta <= raw_vec;
            sync_vec  <= sync_meta;
            presc_q   <= presc_q + TICK_BITS'(1);
            stable_q  <= stable_d;
            state_q   <= state_d;
            changed_q <= |(stable_d ^ stable_q);
            for (int i = 0; i < N; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign bus.a_stable  = stable_q[3:0];
    assign bus.b_stable  = stable_q[7:4];
    assign bus.c0_stable = stable_q[8];
    assign bus.changed   = changed_q;
    assign bus.tick      = tick;
endmodule

// File: tb/tb_operand_debouncer.sv
// Directed bench for operand_debouncer with a 4-cycle tick; a second instance
// exercises the single-tick acceptance case.
module tb_operand_debouncer;
    logic clk = 1'b0;
    logic clr;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    always #5 clk = ~clk;

    operand_debouncer_if bus();
    operand_debouncer_if bus1();

    operand_debouncer #(.TICK_BITS(2), .STABLE_COUNT(4), .CNT_W(4)) dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    operand_debouncer #(.TICK_BITS(2), .STABLE_COUNT(1), .CNT_W(4)) dut1 (
        .clk (clk),
        .clr (clr),
        .bus (bus1)
    );

    // Cycle N is the interval after the Nth clock edge since the reset anchor.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset(input int n);
        clr = 1'b0;
        for (int i = 0; i < n; i++) step();
        clr = 1'b1;
        cyc = 0;
    endtask

    task automatic test_reset();
        bus.raw_a = 4'hF;
        clr = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++;
            if ({bus.a_stable, bus.changed, bus.tick} !== 6'b0) begin
                failures++;
                $display("[TB] FAIL reset_hold i=%0d got a=%h chg=%b tick=%b exp all 0",
                         i, bus.a_stable, bus.changed, bus.tick);
            end
        end
        clr = 1'b1;
        cyc = 0;
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (bus.tick !== 1'(cyc == 3)) begin
                failures++;
                $display("[TB] FAIL first_tick cyc=%0d got=%b exp=%b", cyc, bus.tick, (cyc == 3));
            end
            step();
        end
    endtask

    task automatic test_clean_change();
        int pulses;
        logic [8:0] exp_v;
        bus.raw_a = 4'h0; bus.raw_b = 4'h0; bus.raw_c0 = 1'b0;
        do_reset(2);
        bus.raw_a = 4'h5; bus.raw_b = 4'hA; bus.raw_c0 = 1'b1;
        pulses = 0;
        while (cyc < 20) begin
            step();
            exp_v = (cyc >= 16) ? 9'h1A5 : 9'h000;
            checks++;
            if ({bus.c0_stable, bus.b_stable, bus.a_stable} !== exp_v) begin
                failures++;
                $display("[TB] FAIL clean_outputs cyc=%0d got=%h exp=%h", cyc,
                         {bus.c0_stable, bus.b_stable, bus.a_stable}, exp_v);
            end
            checks++;
            if (bus.changed !== 1'(cyc == 16)) begin
                failures++;
                $display("[TB] FAIL clean_changed cyc=%0d got=%b exp=%b", cyc, bus.changed, (cyc == 16));
            end
            if (bus.changed === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 1) begin
            failures++;
            $display("[TB] FAIL clean_pulse_count got=%0d exp=1", pulses);
        end
    endtask

    task automatic test_glitch();
        logic [3:0] exp_a;
        bus.raw_a = 4'h4;
        while (cyc < 40) begin
            step();
            if (cyc == 28) bus.raw_a = 4'h5;
            checks++;
            if (bus.a_stable !== 4'h5 || bus.changed !== 1'b0) begin
                failures++;
                $display("[TB] FAIL glitch_reject cyc=%0d got a=%h chg=%b exp a=5 chg=0",
                         cyc, bus.a_stable, bus.changed);
            end
        end
        bus.raw_a = 4'h4;
        while (cyc < 58) begin
            step();
            exp_a = (cyc >= 56) ? 4'h4 : 4'h5;
            checks++;
            if (bus.a_stable !== exp_a || bus.changed !== 1'(cyc == 56)) begin
                failures++;
                $display("[TB] FAIL glitch_accept cyc=%0d got a=%h chg=%b exp a=%h chg=%b",
                         cyc, bus.a_stable, bus.changed, exp_a, (cyc == 56));
            end
        end
    endtask

    task automatic test_bounce();
        logic [3:0] exp_b;
        while (cyc < 60) step();
        while (cyc < 100) begin
            bus.raw_b[0] = (((cyc - 60) / 3) % 2 == 0);
            step();
            checks++;
            if (bus.b_stable !== 4'hA || bus.changed !== 1'b0) begin
                failures++;
                $display("[TB] FAIL bounce_hold cyc=%0d got b=%h chg=%b exp b=a chg=0",
                         cyc, bus.b_stable, bus.changed);
            end
        end
        bus.raw_b[0] = 1'b1;
        while (cyc < 116) begin
            step();
            exp_b = (cyc >= 112) ? 4'hB : 4'hA;
            checks++;
            if (bus.b_stable !== exp_b || bus.changed !== 1'(cyc == 112)) begin
                failures++;
                $display("[TB] FAIL bounce_settle cyc=%0d got b=%h chg=%b exp b=%h chg=%b",
                         cyc, bus.b_stable, bus.changed, exp_b, (cyc == 112));
            end
        end
    endtask

    task automatic test_reset_mid();
        bus.raw_a = 4'h0; bus.raw_b = 4'h0; bus.raw_c0 = 1'b0;
        do_reset(2);
        bus.raw_c0 = 1'b1;
        while (cyc < 12) begin
            step();
            checks++;
            if (bus.c0_stable !== 1'b0) begin
                failures++;
                $display("[TB] FAIL midreset_pending cyc=%0d got=%b exp=0", cyc, bus.c0_stable);
            end
        end
        clr = 1'b0;
        step();
        clr = 1'b1;
        cyc = 0;
        checks++;
        if ({bus.c0_stable, bus.changed, bus.tick} !== 3'b000) begin
            failures++;
            $display("[TB] FAIL midreset_clear got c0=%b chg=%b tick=%b exp 000",
                     bus.c0_stable, bus.changed, bus.tick);
        end
        while (cyc < 18) begin
            step();
            checks++;
            if (bus.c0_stable !== 1'(cyc >= 16) || bus.changed !== 1'(cyc == 16)) begin
                failures++;
                $display("[TB] FAIL midreset_recover cyc=%0d got c0=%b chg=%b exp c0=%b chg=%b",
                         cyc, bus.c0_stable, bus.changed, (cyc >= 16), (cyc == 16));
            end
        end
    endtask

    task automatic test_stable_one();
        logic [3:0] exp_a;
        do_reset(2);
        bus1.raw_a = 4'h9;
        while (cyc < 14) begin
            step();
            if (cyc == 4) bus1.raw_a = 4'h8;
            if (cyc == 8) bus1.raw_a = 4'h9;
            exp_a = (cyc < 4) ? 4'h0 : (cyc < 8) ? 4'h9 : (cyc < 12) ? 4'h8 : 4'h9;
            checks++;
            if (bus1.a_stable !== exp_a) begin
                failures++;
                $display("[TB] FAIL sc1_a cyc=%0d got=%h exp=%h", cyc, bus1.a_stable, exp_a);
            end
            checks++;
            if (bus1.changed !== 1'(cyc == 4 || cyc == 8 || cyc == 12)) begin
                failures++;
                $display("[TB] FAIL sc1_changed cyc=%0d got=%b exp=%b", cyc, bus1.changed,
                         (cyc == 4 || cyc == 8 || cyc == 12));
            end
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired at cyc=%0d", cyc);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        clr = 1'b0;
        bus.raw_a = 4'h0;  bus.raw_b = 4'h0;  bus.raw_c0 = 1'b0;
        bus1.raw_a = 4'h0; bus1.raw_b = 4'h0; bus1.raw_c0 = 1'b0;
        test_reset();
        test_clean_change();
        test_glitch();
        test_bounce();
        test_reset_mid();
        test_stable_one();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/operand_debouncer.md
Name: operand_debouncer

Overview:
- Upstream input-conditioning stage for the 4-bit lookahead-adder lab top level.
- Takes the raw, asynchronous slide-switch inputs (operand A, operand B, carry-in) and synchronises and debounces them.
- Presents glitch-free registered operands to the adder, display multiplexer and 7-segment path.
- Flags every accepted change with a one-cycle pulse.

Parameters:
TICK_BITS, 15, width of the internal sample prescaler; one sample tick every 2^TICK_BITS clk cycles (matches the 15-bit slow counter)
STABLE_COUNT, 4, consecutive ticks a differing input must persist before the output adopts it; legal range 1..15
CNT_W, 4, width of each per-bit stability counter; must hold STABLE_COUNT

Ports:
clk  input  1  system clock
clr  input  1  synchronous, active-low reset
raw_a  input  4  raw switch bits for operand A (a3..a0)
raw_b  input  4  raw switch bits for operand B (b3..b0)
raw_c0  input  1  raw carry-in switch
a_stable  output  4  debounced operand A
b_stable  output  4  debounced operand B
c0_stable  output  1  debounced carry-in
changed  output  1  one-cycle pulse: at least one stable bit changed this cycle
tick  output  1  one-cycle sample strobe (debug and bench visibility)

Behaviour:
- Reset (clr==0 at a clk rising edge) clears all of the following to 0:
  - synchroniser flops
  - prescaler
  - all stability counters
  - a_stable, b_stable, c0_stable, changed, tick
- Reset asserted mid-operation aborts any pending bit change; there is no memory of pre-reset inputs.
- Internally, the 9 raw bits are concatenated as vec = {raw_c0, raw_b, raw_a}.
- Synchroniser:
  - Two flops per bit; sync_vec lags raw by 2 clk cycles.
  - No other logic is applied to raw inputs.
- Prescaler:
  - TICK_BITS-bit up-counter with free wrap.
  - tick=1 for exactly one cycle when the counter equals all-ones.
  - The first tick after reset occurs in cycle 2^TICK_BITS - 1.
- Per-bit state machine, two states, 9 independent instances, evaluated only in cycles where tick==1:
  - IDLE (counter==0):
    - If sync bit == stable bit: stay.
    - If they differ: go to PENDING with counter=1.
    - If STABLE_COUNT==1: instead flip the stable bit immediately and stay in IDLE.
  - PENDING:
    - If sync bit == stable bit: return to IDLE and clear the counter (glitch rejected).
    - If it still differs and counter==STABLE_COUNT-1: flip the stable bit, clear the counter, go to IDLE.
    - Otherwise: increment the counter.
  - In non-tick cycles, all state holds.
- Latency:
  - A clean raw transition appears at the output on the STABLE_COUNT-th tick at or after raw+2 cycles.
  - Worst case is 2 + STABLE_COUNT*2^TICK_BITS cycles.
- changed:
  - Registered; asserts in the same cycle the stable outputs update, i.e. the cycle after the deciding tick.
  - Exactly one pulse even when several bits flip on the same tick.
  - Never asserted for rejected glitches.
- Outputs never change except in the cycle following a tick, and never while clr==0.
- Bits never interact; each bit may flip in either direction independently.

Test Plan:
All scenarios use TICK_BITS=2 (tick in every 4th cycle: cycles 3, 7, 11, ...) and STABLE_COUNT=4 unless noted.

1. Reset: hold clr=0 for 5 cycles with raw_a=4'hF → a_stable=0, changed=0, tick=0 throughout; after release, first tick occurs in the 4th cycle.
2. Clean change: after reset, set raw_a=4'h5, raw_b=4'hA, raw_c0=1 and hold → outputs stay 0 for the first 3 ticks; on the 4th tick edge a_stable=5, b_stable=A, c0_stable=1; changed pulses exactly once for 1 cycle.
3. Glitch rejection: outputs stable at a_stable=5; toggle raw_a to 4'h4 for 2 ticks, then back to 4'h5 → a_stable remains 5 and changed never asserts; then hold 4'h4 → a_stable=4 after 4 further ticks.
4. Bounce train: toggle raw_b[0] every 3 cycles for 40 cycles, then hold at 1 → b_stable[0] stays 0 during bouncing and becomes 1 exactly 4 ticks after the sampled value settles.
5. Reset mid-operation: raw_c0 goes 0→1; after 3 ticks pulse clr=0 for one cycle → c0_stable=0 and the pending count is lost; 4 full ticks after release, c0_stable=1.
6. STABLE_COUNT=1: set raw_a=4'h9 → a_stable=9 in the cycle after the first tick that samples it, with one changed pulse; a 1-tick glitch to 4'h8 is passed through as 8, then back to 9.
